// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter
//   Two-requester transmit front end in the clk_2f domain. Each requester
//   writes bytes into its own FIFO. A round-robin arbiter pops at most one
//   byte per cycle into a registered, valid-qualified output stream.
//
// Ports
//   clk_2f, reset                : clock and synchronous active-low reset
//   data_in_0/push_0             : requester 0 byte and write strobe
//   data_in_1/push_1             : requester 1 byte and write strobe
//   th_af                        : almost-full threshold, latched in INIT (0 -> 1)
//   pause_in                     : downstream pause, blocks pops
//   data_out/valid_out/grant_out : registered output byte, qualifier, source FIFO
//   almost_full_x/full_x/empty_x : per-FIFO occupancy flags
//   active_out                   : FSM is in ACTIVE
//   error_out                    : sticky overflow (push dropped on a full FIFO)
//
// State table
//   state     | meaning
//   ST_RESET  | held while reset=0, everything cleared
//   ST_INIT   | one cycle, latch the almost-full threshold
//   ST_IDLE   | both FIFOs empty, no arbitration
//   ST_ACTIVE | arbitrating and popping unless paused
module phy_tx_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              push_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              push_1,
    input  logic [AW:0]       th_af,
    input  logic              pause_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              grant_out,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              full_0,
    output logic              full_1,
    output logic              empty_0,
    output logic              empty_1,
    output logic              active_out,
    output logic              error_out
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem_0 [DEPTH];
    logic [DATA_W-1:0] mem_1 [DEPTH];
    logic [AW-1:0]     wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
    logic [AW:0]       count_0, count_1;
    logic [AW:0]       th_q;
    logic              last_grant;

    logic accept_0, accept_1, ovf;
    logic pop_en, pop_0, pop_1, tie;

    // Flags come straight from the registered counts.
    assign empty_0 = (count_0 == '0);
    assign empty_1 = (count_1 == '0);
    assign full_0  = (count_0 == CNT_FULL);
    assign full_1  = (count_1 == CNT_FULL);

    // The threshold is not valid until INIT has latched it.
    assign almost_full_0 = (state == ST_IDLE || state == ST_ACTIVE) && (count_0 >= th_q);
    assign almost_full_1 = (state == ST_IDLE || state == ST_ACTIVE) && (count_1 >= th_q);

    assign active_out = (state == ST_ACTIVE);

    // Full is judged on the pre-pop count, so a push to a full FIFO is
    // dropped even when the same cycle frees an entry.
    assign accept_0 = push_0 && !full_0 && (state != ST_RESET);
    assign accept_1 = push_1 && !full_1 && (state != ST_RESET);
    assign ovf      = (state != ST_RESET) && ((push_0 && full_0) || (push_1 && full_1));

    // On a tie the FIFO opposite last_grant wins; last_grant only moves on ties.
    assign pop_en = (state == ST_ACTIVE) && !pause_in;
    assign tie    = !empty_0 && !empty_1;
    assign pop_0  = pop_en && !empty_0 && (empty_1 || last_grant);
    assign pop_1  = pop_en && !empty_1 && (empty_0 || !last_grant);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = ST_IDLE;
            ST_IDLE:   if (!empty_0 || !empty_1) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (empty_0 && empty_1)   state_nxt = ST_IDLE;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (!reset) state <= ST_RESET;
        else        state <= state_nxt;
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk_2f) begin
        if (accept_0) mem_0[wr_ptr_0] <= data_in_0;
        if (accept_1) mem_1[wr_ptr_1] <= data_in_1;
    end

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            wr_ptr_0   <= '0;
            rd_ptr_0   <= '0;
            wr_ptr_1   <= '0;
            rd_ptr_1   <= '0;
            count_0    <= '0;
            count_1    <= '0;
            th_q       <= CNT_FULL;
            last_grant <= 1'b1;
            data_out   <= '0;
            valid_out  <= 1'b0;
            grant_out  <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            if (accept_0) wr_ptr_0 <= wr_ptr_0 + PTR_ONE;
            if (accept_1) wr_ptr_1 <= wr_ptr_1 + PTR_ONE;
            if (pop_0)    rd_ptr_0 <= rd_ptr_0 + PTR_ONE;
            if (pop_1)    rd_ptr_1 <= rd_ptr_1 + PTR_ONE;

            case ({accept_0, pop_0})
                2'b10:   count_0 <= count_0 + CNT_ONE;
                2'b01:   count_0 <= count_0 - CNT_ONE;
                default: count_0 <= count_0;
            endcase
            case ({accept_1, pop_1})
                2'b10:   count_1 <= count_1 + CNT_ONE;
                2'b01:   count_1 <= count_1 - CNT_ONE;
                default: count_1 <= count_1;
            endcase

            if (ovf) error_out <= 1'b1;

            if (state == ST_INIT) th_q <= (th_af == '0) ? CNT_ONE : th_af;

            if (pop_0 || pop_1) begin
                data_out  <= pop_1 ? mem_1[rd_ptr_1] : mem_0[rd_ptr_0];
                grant_out <= pop_1;
                valid_out <= 1'b1;
                if (tie) last_grant <= pop_1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Self-checking bench for phy_tx_arbiter: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
module tb_phy_tx_arbiter;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    logic              clk_2f = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in_0, data_in_1;
    logic              push_0, push_1;
    logic [AW:0]       th_af;
    logic              pause_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out, grant_out;
    logic              almost_full_0, almost_full_1, full_0, full_1, empty_0, empty_1;
    logic              active_out, error_out;

    phy_tx_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk_2f        (clk_2f),
        .reset         (reset),
        .data_in_0     (data_in_0),
        .push_0        (push_0),
        .data_in_1     (data_in_1),
        .push_1        (push_1),
        .th_af         (th_af),
        .pause_in      (pause_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .grant_out     (grant_out),
        .almost_full_0 (almost_full_0),
        .almost_full_1 (almost_full_1),
        .full_0        (full_0),
        .full_1        (full_1),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .active_out    (active_out),
        .error_out     (error_out)
    );

    always #5 clk_2f = ~clk_2f;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic       g;
        logic [7:0] d;
    } ev_t;
    ev_t log_q[$];

    // Reference model: FIFOs as queues, a three-phase bring-up and an
    // "arbitrating" flag derived from the operating rules.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_phase;
    bit         m_act;
    int         m_th;
    bit         m_last;
    logic [7:0] m_dout;
    bit         m_valid, m_grant, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        int n0, n1, pick;
        if (!reset) begin
            q0.delete();
            q1.delete();
            m_phase = 0;
            m_act   = 0;
            m_th    = DEPTH;
            m_last  = 1;
            m_dout  = '0;
            m_valid = 0;
            m_grant = 0;
            m_err   = 0;
            return;
        end
        n0   = q0.size();
        n1   = q1.size();
        pick = -1;
        if (m_phase == 2 && m_act && !pause_in) begin
            if (n0 > 0 && n1 > 0) begin
                pick   = m_last ? 0 : 1;
                m_last = (pick == 1);
            end else if (n0 > 0) pick = 0;
            else if (n1 > 0)     pick = 1;
        end
        if (pick == 0) begin
            m_dout = q0.pop_front(); m_valid = 1; m_grant = 0;
        end else if (pick == 1) begin
            m_dout = q1.pop_front(); m_valid = 1; m_grant = 1;
        end else begin
            m_valid = 0;
        end
        if (m_phase != 0) begin
            if (push_0) begin
                if (n0 < DEPTH) q0.push_back(data_in_0); else m_err = 1;
            end
            if (push_1) begin
                if (n1 < DEPTH) q1.push_back(data_in_1); else m_err = 1;
            end
        end
        case (m_phase)
            0: m_phase = 1;
            1: begin
                m_th    = (th_af == 0) ? 1 : int'(th_af);
                m_phase = 2;
                m_act   = 0;
            end
            default: begin
                if (!m_act) m_act = (n0 > 0 || n1 > 0);
                else if (n0 == 0 && n1 == 0) m_act = 0;
            end
        endcase
    endtask

    task automatic tick();
        logic [5:0] flags_exp;
        int s0, s1;
        @(posedge clk_2f);
        model_step();
        #1;
        cyc++;
        s0 = q0.size();
        s1 = q1.size();
        flags_exp = {(m_phase == 2) && (s0 >= m_th), (m_phase == 2) && (s1 >= m_th),
                     s0 == DEPTH, s1 == DEPTH, s0 == 0, s1 == 0};
        check("valid_out", valid_out, m_valid);
        check("data_out", data_out, m_dout);
        check("grant_out", grant_out, m_grant);
        check("flags", {almost_full_0, almost_full_1, full_0, full_1, empty_0, empty_1}, flags_exp);
        check("active_out", active_out, (m_phase == 2) && m_act);
        check("error_out", error_out, m_err);
        if (valid_out) log_q.push_back('{cyc, grant_out, data_out});
    endtask

    task automatic idle(input int n);
        push_0 = 0;
        push_1 = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n, input logic [AW:0] th);
        th_af  = th;
        reset  = 0;
        push_0 = 0;
        push_1 = 0;
        for (int i = 0; i < n; i++) tick();
        reset = 1;
        tick();
        tick();
    endtask

    initial begin
        int c0;
        reset = 0; push_0 = 0; push_1 = 0; data_in_0 = '0; data_in_1 = '0;
        th_af = 3'd3; pause_in = 0;

        // Reset / init
        tick();
        check("rst_empty", {empty_1, empty_0}, 2'b11);
        check("rst_valid", valid_out, 1'b0);
        check("rst_error", error_out, 1'b0);
        tick(); tick();
        reset = 1;
        tick();
        check("init_not_active", active_out, 1'b0);
        tick();
        pause_in = 1;
        push_0 = 1;
        for (int i = 0; i < 3; i++) begin
            data_in_0 = 8'h50 + 8'(i);
            tick();
            if (i == 1) check("af0_below_th", almost_full_0, 1'b0);
        end
        check("af0_at_th", almost_full_0, 1'b1);
        push_0 = 0;
        pause_in = 0;
        idle(6);

        // Single requester
        log_q.delete();
        c0 = cyc + 1;
        push_0 = 1;
        data_in_0 = 8'hA1; tick();
        data_in_0 = 8'hA2; tick();
        data_in_0 = 8'hA3; tick();
        idle(5);
        check("single_len", log_q.size(), 3);
        check("single_idle", active_out, 1'b0);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            check("single_data", log_q[i].d, 8'hA1 + 8'(i));
            check("single_grant", log_q[i].g, 1'b0);
            check("single_cycle", log_q[i].cyc, c0 + 2 + i);
        end

        // Round-robin from a fresh reset
        do_reset(1, 3'd4);
        log_q.delete();
        pause_in = 1;
        push_0 = 1; push_1 = 1;
        data_in_0 = 8'h10; data_in_1 = 8'h20; tick();
        data_in_0 = 8'h11; data_in_1 = 8'h21; tick();
        push_0 = 0; push_1 = 0;
        tick();
        pause_in = 0;
        idle(6);
        begin
            logic [7:0] rr_d [4];
            logic       rr_g [4];
            rr_d = '{8'h10, 8'h20, 8'h11, 8'h21};
            rr_g = '{1'b0, 1'b1, 1'b0, 1'b1};
            check("rr_len", log_q.size(), 4);
            for (int i = 0; i < 4 && i < log_q.size(); i++) begin
                check("rr_data", log_q[i].d, rr_d[i]);
                check("rr_grant", log_q[i].g, rr_g[i]);
            end
        end

        // Overflow on FIFO 1
        log_q.delete();
        pause_in = 1;
        push_1 = 1;
        for (int i = 0; i < 5; i++) begin
            data_in_1 = 8'h60 + 8'(i);
            tick();
            if (i == 3) begin
                check("ovf_full_after4", full_1, 1'b1);
                check("ovf_no_err_yet", error_out, 1'b0);
            end
        end
        check("ovf_err", error_out, 1'b1);
        push_1 = 0;
        pause_in = 0;
        idle(7);
        check("ovf_len", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) check("ovf_data", log_q[i].d, 8'h60 + 8'(i));
        check("ovf_sticky", error_out, 1'b1);

        // Streaming with pointer wrap
        log_q.delete();
        c0 = cyc + 1;
        push_0 = 1;
        for (int i = 0; i < 12; i++) begin
            data_in_0 = 8'h30 + 8'(i);
            tick();
        end
        idle(6);
        check("stream_len", log_q.size(), 12);
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            check("stream_data", log_q[i].d, 8'h30 + 8'(i));
            check("stream_cycle", log_q[i].cyc, c0 + 2 + i);
        end

        // Mid-operation reset
        pause_in = 1;
        push_0 = 1;
        for (int i = 0; i < 4; i++) begin
            data_in_0 = 8'h70 + 8'(i);
            tick();
        end
        push_0 = 0;
        pause_in = 0;
        tick();
        check("mr_valid_before", valid_out, 1'b1);
        reset = 0;
        tick();
        check("mr_data", data_out, 8'h00);
        check("mr_valid", valid_out, 1'b0);
        check("mr_empty0", empty_0, 1'b1);
        check("mr_error", error_out, 1'b0);
        reset = 1;
        log_q.delete();
        idle(10);
        check("mr_no_stale", log_q.size(), 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                th_af = 3'($urandom_range(0, DEPTH));
                reset = 0;
            end else begin
                reset = 1;
            end
            push_0    = $urandom_range(0, 1);
            push_1    = $urandom_range(0, 2) == 0;
            data_in_0 = 8'($urandom);
            data_in_1 = 8'($urandom);
            pause_in  = $urandom_range(0, 3) == 0;
            tick();
        end
        reset = 1;
        pause_in = 0;
        idle(12);
        check("final_idle", active_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
